// File: rtl/gray_seq_checker_if.sv
// Sample/result bundle between a Gray stream source and gray_seq_checker.
// The master drives samples; the slave (the checker) returns binary value and status.
interface gray_seq_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic [WIDTH-1:0]     gray_in;
  logic                 bin_valid;
  logic [WIDTH-1:0]     bin_out;
  logic                 locked;
  logic                 step_err;
  logic                 wrap;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, gray_in,
    input  bin_valid, bin_out, locked, step_err, wrap, err_count
  );

  modport slave (
    input  in_valid, gray_in,
    output bin_valid, bin_out, locked, step_err, wrap, err_count
  );
endinterface

// File: rtl/gray_seq_checker.sv
// Gray stream checker: converts each sample to binary and verifies +1 steps, with lock/wrap/error reporting.
// Optional macro GRAY_CHK_ALLOW_HOLD_EN makes a repeated sample neutral instead of a bad step.
module gray_seq_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_CNT  = 2
) (
  input logic              clk,
  input logic              rst,
  gray_seq_checker_if.slave bus
);

  localparam int GCW = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
  localparam logic [WIDTH-1:0]     BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [GCW-1:0]       LOCK_VAL = GCW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t               r_state;
  logic [WIDTH-1:0]     r_prev_bin;
  logic [GCW-1:0]       r_good_cnt;
  logic                 r_bin_valid;
  logic [WIDTH-1:0]     r_bin_out;
  logic                 r_locked;
  logic                 r_step_err;
  logic                 r_wrap;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic [WIDTH-1:0] w_new_bin;
  logic [GCW-1:0]   w_cnt_inc;
  logic             w_good;
  logic             w_repeat;
  logic             w_hold;
  logic             w_tracking;
  logic             w_bad;
  logic             w_wrap;

  assign w_new_bin  = gray2bin(bus.gray_in);
  assign w_cnt_inc  = r_good_cnt + GCW'(1);
  assign w_good     = (w_new_bin == (r_prev_bin + WIDTH'(1)));
  assign w_repeat   = (w_new_bin == r_prev_bin);
  assign w_tracking = (r_state == ACQUIRE) || (r_state == LOCKED);

`ifdef GRAY_CHK_ALLOW_HOLD_EN
  assign w_hold = w_repeat;
`else
  assign w_hold = 1'b0;
`endif

  assign w_bad  = bus.in_valid && w_tracking && !w_good && !w_hold;
  assign w_wrap = bus.in_valid && (r_state == LOCKED) && w_good && (r_prev_bin == BIN_MAX);

  // Sample acceptance, step classification, lock FSM and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prev_bin  <= '0;
      r_good_cnt  <= '0;
      r_bin_valid <= 1'b0;
      r_bin_out   <= '0;
      r_locked    <= 1'b0;
      r_step_err  <= 1'b0;
      r_wrap      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_bin_valid <= bus.in_valid;
      r_step_err  <= w_bad;
      r_wrap      <= w_wrap;
      if (w_bad && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
      if (bus.in_valid) begin
        // Every accepted sample becomes the new reference, so a jump resynchronises.
        r_bin_out  <= w_new_bin;
        r_prev_bin <= w_new_bin;
        case (r_state)
          IDLE: begin
            r_good_cnt <= '0;
            r_state    <= ACQUIRE;
            r_locked   <= 1'b0;
          end
          ACQUIRE: begin
            if (w_good) begin
              r_good_cnt <= w_cnt_inc;
              if (w_cnt_inc == LOCK_VAL) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else if (!w_hold) begin
              r_good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!w_good && !w_hold) begin
              r_good_cnt <= '0;
              r_state    <= ACQUIRE;
              r_locked   <= 1'b0;
            end
          end
          default: begin
            r_good_cnt <= '0;
            r_state    <= IDLE;
            r_locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bin_valid = r_bin_valid;
  assign bus.bin_out   = r_bin_out;
  assign bus.locked    = r_locked;
  assign bus.step_err  = r_step_err;
  assign bus.wrap      = r_wrap;
  assign bus.err_count = r_err_count;

endmodule

// File: doc/gray_seq_checker.md
# gray_seq_checker

Downstream consumer of the 4-bit Gray counter output. Samples a Gray-coded value stream, converts it to binary, and checks that every accepted sample is exactly one count past the previous one (modulo 2^WIDTH). Reports lock status, single-cycle error and wrap pulses, and a saturating error count. Used as the in-design checker and as the binary-domain feed for downstream logic.

## Interface
- WIDTH, default 4: Gray/binary word width (≥2).
- ERR_CNT_W, default 8: error counter width.
- LOCK_CNT, default 2: consecutive good steps required to enter LOCKED (≥1).

- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  gray_in is sampled this cycle.
- gray_in  input  WIDTH  Gray-coded sample.
- bin_valid  output  1  bin_out updated (registered in_valid).
- bin_out  output  WIDTH  binary of last accepted sample.
- locked  output  1  stream tracking correctly.
- step_err  output  1  one-cycle pulse: bad step detected.
- wrap  output  1  one-cycle pulse: good step from all-ones to zero while LOCKED.
- err_count  output  ERR_CNT_W  saturating count of step_err pulses.

## Operation
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i], for i from WIDTH-2 down to 0. The conversion is combinational ahead of the output register.
- Registers held: prev_bin (WIDTH), good_cnt (sized to hold LOCK_CNT), state.
- Good step: new_bin == prev_bin + 1, in WIDTH-bit arithmetic, so all-ones followed by zero is good.
- Repeat: new_bin == prev_bin.
- Bad step: anything else, plus repeat when the macro is off.
- States:
  - IDLE: no previous sample. The first valid sample loads prev_bin, clears good_cnt, and moves to ACQUIRE. It is never an error.
  - ACQUIRE, good step: good_cnt+1. When good_cnt+1 == LOCK_CNT, move to LOCKED.
  - ACQUIRE, bad step: good_cnt=0, step_err pulse, stay in ACQUIRE.
  - LOCKED, good step: stay in LOCKED.
  - LOCKED, bad step: step_err pulse, good_cnt=0, move to ACQUIRE.
- Every valid sample, good or bad, overwrites prev_bin. This lets the checker resynchronise on a new sequence.
- in_valid low: no state, prev_bin or good_cnt change, and no pulses. Gaps of any length are legal.
- err_count increments on each step_err and holds at all-ones; it never wraps.
- locked is high exactly while state == LOCKED.

## Timing
- Latency is 1 cycle. A sample taken on edge N drives bin_valid, bin_out, step_err, wrap and locked, plus the updated err_count, after edge N+1.
- step_err and wrap are high for exactly one cycle per triggering sample. They are never both high.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.
- Reset values: state=IDLE, bin_valid=0, bin_out=0, locked=0, step_err=0, wrap=0, err_count=0, prev_bin=0, good_cnt=0.
- rst has priority over in_valid. A sample presented in the same cycle as rst is discarded.
- Reset mid-operation returns the block to IDLE. The next sample after reset is treated as a first sample.

## Configuration
- GRAY_CHK_ALLOW_HOLD_EN defined: a repeat sample is neutral.
  - No step_err and no state change.
  - good_cnt unchanged.
  - bin_valid and bin_out still update.
- Undefined: a repeat is a bad step, handled per the state rules above.

## Test plan
- Reset, then gray 0,1,3,2 on consecutive cycles -> bin_out 0,1,2,3. locked rises 1 cycle after the third sample. step_err never asserts and err_count=0.
- Lock, then run the full 16-value Gray sequence through 8 (bin 15) to 0 -> wrap pulses once, 1 cycle after the 0 sample. locked stays high.
- While LOCKED at bin 5, present gray for bin 7 -> step_err pulse, locked drops, err_count=1. Then bins 8,9 -> locked re-asserts after bin 9.
- While LOCKED at bin 3, present bin 3 again:
  - Macro off -> step_err, locked=0.
  - Macro on -> no pulse, locked=1.
- Valid samples 0,1 with 5 idle cycles between them, then 2 -> no errors, and lock is reached exactly as in the back-to-back case.
- With ERR_CNT_W=2, drive 5 bad steps -> err_count 1,2,3,3,3. Then assert rst while LOCKED -> all outputs 0 next cycle and state IDLE.
